// File: rtl/sim_mem_pkg.sv
// Shared types and limits for the simulation memory responder.
package sim_mem_pkg;
  localparam int MaxOutstandingLimit = 4;
  localparam int RespLatencyLimit    = 8;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [2:0]  dly;
  } resp_entry_t;
endpackage

// File: rtl/sim_mem_resp_fifo.sv
// In-order response queue; every entry counts its own delay down to zero.
// The head is ready to pop once its delay has expired.
module sim_mem_resp_fifo
  import sim_mem_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  resp_entry_t push_entry_i,
  input  logic        pop_i,
  output logic        head_err_o,
  output logic [31:0] head_rdata_o,
  output logic        head_ready_o,
  output logic [2:0]  count_o
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  resp_entry_t     entries_q [Depth];
  resp_entry_t     entries_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]      count_q, count_d;
  resp_entry_t     head;

  assign head         = entries_q[rd_ptr_q];
  assign head_err_o   = head.err;
  assign head_rdata_o = head.rdata;
  assign head_ready_o = (count_q != 3'd0) && (head.dly == 3'd0);
  assign count_o      = count_q;

  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + {2'b00, push_i} - {2'b00, pop_i};
    // Free slots also tick down; they are overwritten on push so this is harmless.
    for (int i = 0; i < Depth; i++) begin
      if (entries_q[i].dly != 3'd0) begin
        entries_d[i].dly = entries_q[i].dly - 3'd1;
      end
    end
    if (push_i) begin
      entries_d[wr_ptr_q] = push_entry_i;
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        entries_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 3'd0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end
endmodule

// File: rtl/sim_mem_responder.sv
// Simulation memory on the req/gnt/rvalid/err protocol with grant stall, fixed
// response latency, bounded outstanding requests and an error address window.
module sim_mem_responder
  import sim_mem_pkg::*;
#(
  parameter int          Depth          = 16384,
  parameter int          MaxOutstanding = 2,
  parameter int          GntStallCycles = 0,
  parameter int          RespLatency    = 1,
  parameter logic [31:0] ErrBase        = 32'hFFFF_F000,
  parameter logic [31:0] ErrMask        = 32'hFFFF_F000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  localparam int IdxW = $clog2(Depth);
  localparam bit ParamsOk = (MaxOutstanding >= 1) && (MaxOutstanding <= MaxOutstandingLimit)
                         && (RespLatency >= 1) && (RespLatency <= RespLatencyLimit)
                         && (GntStallCycles >= 0) && (Depth >= 2)
                         && ((Depth & (Depth - 1)) == 0);

  logic [31:0]     mem_q [Depth];
  logic [IdxW-1:0] idx;
  logic            err_hit;
  logic [31:0]     stall_cnt_q, stall_cnt_d;
  logic [2:0]      count;
  logic            head_ready, head_err, pop, full_eff;
  logic [31:0]     head_rdata;
  resp_entry_t     push_entry;

  assign idx      = addr_i[2 +: IdxW];
  assign err_hit  = (addr_i & ErrMask) == ErrBase;
  assign pop      = head_ready;
  assign full_eff = (count == 3'(MaxOutstanding)) && !pop;
  // rst_ni gates the grant so it reads 0 while reset is held.
  assign gnt_o    = rst_ni && req_i && (stall_cnt_q == 32'(GntStallCycles)) && !full_eff;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!req_i || gnt_o) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != 32'(GntStallCycles)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.err   = err_hit;
    push_entry.rdata = (err_hit || we_i) ? 32'h0 : mem_q[idx];
    push_entry.dly   = 3'(RespLatency - 1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && !err_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  sim_mem_resp_fifo #(
    .Depth (MaxOutstanding)
  ) u_resp_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (gnt_o),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_err_o   (head_err),
    .head_rdata_o (head_rdata),
    .head_ready_o (head_ready),
    .count_o      (count)
  );

  assign rvalid_o = pop;
  assign rdata_o  = pop ? head_rdata : 32'h0;
  assign err_o    = pop && head_err;

  a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (req_i && !gnt_o) |=> ($stable(addr_i) && $stable(we_i) && $stable(be_i) && $stable(wdata_i)));
  a_count_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count <= 3'(MaxOutstanding));
  a_params : assert property (@(posedge clk_i) ParamsOk);
endmodule

// File: tb/tb_sim_mem_responder.sv
// Directed bench: default, stalled/long-latency and outstanding-limit instances.
module tb_sim_mem_responder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        d_req, d_gnt, d_we, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        s_req, s_gnt, s_we, s_rvalid, s_err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic        m_req, m_gnt, m_we, m_rvalid, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  int n_cmp = 0;
  int n_err = 0;

  sim_mem_responder u_def (
    .clk_i(clk), .rst_ni(rst_n), .req_i(d_req), .gnt_o(d_gnt), .addr_i(d_addr),
    .we_i(d_we), .be_i(d_be), .wdata_i(d_wdata), .rvalid_o(d_rvalid),
    .rdata_o(d_rdata), .err_o(d_err)
  );

  sim_mem_responder #(.GntStallCycles(3), .RespLatency(4)) u_stall (
    .clk_i(clk), .rst_ni(rst_n), .req_i(s_req), .gnt_o(s_gnt), .addr_i(s_addr),
    .we_i(s_we), .be_i(s_be), .wdata_i(s_wdata), .rvalid_o(s_rvalid),
    .rdata_o(s_rdata), .err_o(s_err)
  );

  sim_mem_responder #(.MaxOutstanding(2), .RespLatency(3)) u_mo (
    .clk_i(clk), .rst_ni(rst_n), .req_i(m_req), .gnt_o(m_gnt), .addr_i(m_addr),
    .we_i(m_we), .be_i(m_be), .wdata_i(m_wdata), .rvalid_o(m_rvalid),
    .rdata_o(m_rdata), .err_o(m_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; single access on the default instance, latency 1.
  task automatic d_op(input string tag, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    d_req = 1'b1; d_we = we; d_addr = addr; d_be = be; d_wdata = wdata;
    @(negedge clk);
    check({tag, "_gnt"}, 32'(d_gnt), 32'd1);
    check({tag, "_rv_early"}, 32'(d_rvalid), 32'd0);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check({tag, "_rvalid"}, 32'(d_rvalid), 32'd1);
    check({tag, "_rdata"}, d_rdata, exp_rdata);
    check({tag, "_err"}, 32'(d_err), 32'(exp_err));
    @(posedge clk); #1;
  endtask

  task automatic m_write(input logic [31:0] addr, input logic [31:0] wdata);
    logic got;
    got = 1'b0;
    m_req = 1'b1; m_we = 1'b1; m_addr = addr; m_be = 4'hF; m_wdata = wdata;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = m_gnt;
      if (!got) begin
        @(posedge clk); #1;
      end
    end
    check("m_preload_gnt", 32'(got), 32'd1);
    @(posedge clk); #1;
    m_req = 1'b0; m_we = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd_addr [3];
    logic [31:0] rd_data [3];
    logic [7:0]  exp_gnt, exp_rv;
    int k, r;

    rd_addr = '{32'h40, 32'h44, 32'h48};
    rd_data = '{32'h0000_A001, 32'h0000_B002, 32'h0000_C003};
    d_req = 0; d_we = 0; d_addr = 0; d_be = 0; d_wdata = 0;
    s_req = 0; s_we = 0; s_addr = 0; s_be = 0; s_wdata = 0;
    m_req = 0; m_we = 0; m_addr = 0; m_be = 0; m_wdata = 0;
    rst_n = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(d_gnt), 32'd0);
    check("rst_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_rdata", d_rdata, 32'd0);
    check("rst_err", 32'(d_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Defaults: write then read
    d_op("t1_wr", 1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
    d_op("t1_rd", 1'b0, 32'h100, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Byte enables
    d_op("t2_pre", 1'b1, 32'h200, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
    d_op("t2_wr", 1'b1, 32'h200, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b0);
    d_op("t2_rd", 1'b0, 32'h200, 4'h0, 32'h0, 32'h11BB_33DD, 1'b0);

    // Stall 3, latency 4: gnt at cycle 3, rvalid at cycle 7
    s_req = 1'b1; s_we = 1'b1; s_addr = 32'h300; s_be = 4'hF; s_wdata = 32'h1234_5678;
    for (int c = 0; c < 9; c++) begin
      if (c == 4) begin
        s_req = 1'b0; s_we = 1'b0;
      end
      @(negedge clk);
      check($sformatf("t3_gnt_c%0d", c), 32'(s_gnt), 32'(c == 3));
      check($sformatf("t3_rv_c%0d", c), 32'(s_rvalid), 32'(c == 7));
      if (c == 7) begin
        check("t3_err", 32'(s_err), 32'd0);
        check("t3_rdata", s_rdata, 32'd0);
      end
      @(posedge clk); #1;
    end

    // Outstanding limit 2, latency 3
    for (int i = 0; i < 3; i++) m_write(rd_addr[i], rd_data[i]);
    exp_gnt = 8'b0000_1011;
    exp_rv  = 8'b0101_1000;
    k = 0; r = 0;
    m_we = 1'b0; m_be = 4'h0; m_req = 1'b1; m_addr = rd_addr[0];
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("t4_gnt_c%0d", c), 32'(m_gnt), 32'(exp_gnt[c]));
      check($sformatf("t4_rv_c%0d", c), 32'(m_rvalid), 32'(exp_rv[c]));
      if (exp_rv[c]) begin
        check($sformatf("t4_rdata_%0d", r), m_rdata, rd_data[r]);
        r++;
      end
      if (m_gnt) k++;
      @(posedge clk); #1;
      m_req = (k < 3);
      if (k < 3) m_addr = rd_addr[k];
    end
    m_req = 1'b0;

    // Error window
    d_op("t5_pre4", 1'b1, 32'h10, 4'hF, 32'h55AA_55AA, 32'h0, 1'b0);
    d_op("t5_prea", 1'b1, 32'hF010, 4'hF, 32'h0F0F_0F0F, 32'h0, 1'b0);
    d_op("t5_rd_err", 1'b0, 32'hFFFF_F010, 4'h0, 32'h0, 32'h0, 1'b1);
    d_op("t5_wr_err", 1'b1, 32'hFFFF_F010, 4'hF, 32'h1234_5678, 32'h0, 1'b1);
    d_op("t5_chk4", 1'b0, 32'h10, 4'h0, 32'h0, 32'h55AA_55AA, 1'b0);
    d_op("t5_chka", 1'b0, 32'hF010, 4'h0, 32'h0, 32'h0F0F_0F0F, 1'b0);

    // Reset with two responses pending
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h40;
    @(negedge clk);
    check("t6_gnt0", 32'(m_gnt), 32'd1);
    @(posedge clk); #1;
    m_addr = 32'h44;
    @(negedge clk);
    check("t6_gnt1", 32'(m_gnt), 32'd1);
    @(posedge clk); #1;
    m_req = 1'b0;
    @(negedge clk);
    check("t6_rv_c2", 32'(m_rvalid), 32'd0);
    @(posedge clk); #1;
    check("t6_rv_c3", 32'(m_rvalid), 32'd1);
    check("t6_rdata_c3", m_rdata, 32'h0000_A001);
    rst_n = 1'b0;
    #1;
    check("t6_rst_rvalid", 32'(m_rvalid), 32'd0);
    check("t6_rst_rdata", m_rdata, 32'd0);
    check("t6_rst_err", 32'(m_err), 32'd0);
    check("t6_rst_gnt", 32'(m_gnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("t6_stale_c%0d", c), 32'(m_rvalid), 32'd0);
      @(posedge clk); #1;
    end
    m_req = 1'b1; m_addr = 32'h48;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) check("t6_post_gnt", 32'(m_gnt), 32'd1);
      check($sformatf("t6_post_rv_c%0d", c), 32'(m_rvalid), 32'(c == 3));
      if (c == 3) check("t6_post_rdata", m_rdata, 32'h0000_C003);
      @(posedge clk); #1;
      m_req = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
